prog_clock_divider: RTL and testbench

//   Multi-channel programmable clock divider for the 100 MHz board clock.

---
 rtl/prog_clock_divider_pkg.sv | 10 +
 rtl/prog_clock_divider_if.sv | 32 +++
 rtl/prog_clock_divider_div_channel.sv | 75 +++++++
 rtl/prog_clock_divider.sv | 45 ++++
 tb/tb_prog_clock_divider.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider: shared half-period presets and widths.
// Presets assume the 100 MHz board clock.
package prog_clock_divider_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned HALF_150KHZ = 332;
  localparam int unsigned HALF_1KHZ   = 49999;
  localparam int unsigned HALF_25MHZ  = 1;

endpackage

// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider: control/status bundle between host and divider.
// master drives enables and loads, slave returns the divided outputs.
interface prog_clock_divider_if
  import prog_clock_divider_pkg::*;
#(
  parameter int CH    = 2,
  parameter int CH_W  = 1,
  parameter int CNT_W = int'(CNT_W_DEF)
);

  logic [CH-1:0]    i_en;
  logic             i_restart;
  logic             i_load;
  logic [CH_W-1:0]  i_load_ch;
  logic [CNT_W-1:0] i_load_half;
  logic [CH-1:0]    o_pend;
  logic [CH-1:0]    o_clk_out;
  logic [CH-1:0]    o_tick;

  modport master (
    output i_en, i_restart, i_load,
    output i_load_ch, i_load_half,
    input  o_pend, o_clk_out, o_tick
  );

  modport slave (
    input  i_en, i_restart, i_load,
    input  i_load_ch, i_load_half,
    output o_pend, o_clk_out, o_tick
  );

endinterface

// File: rtl/prog_clock_divider_div_channel.sv
// div_channel: one half-period counter with shadowed limit.
// A new limit only takes effect at a wrap, so phases are never cut short.
module div_channel
  import prog_clock_divider_pkg::*;
#(
  parameter int CNT_W    = int'(CNT_W_DEF),
  parameter int DEF_HALF = int'(HALF_150KHZ)
)(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_half,
  output logic             o_pend,
  output logic             o_clk_out,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] L_DEF = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_active);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_active <= L_DEF;
      r_shadow <= L_DEF;
      r_pend   <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_restart) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
      end else if (!i_en) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        if (r_pend) begin
          r_active <= r_shadow;
          r_pend   <= 1'b0;
        end
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_tick <= ~r_clk;
        if (r_pend) begin
          r_active <= r_shadow;
          r_pend   <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A write on a wrap cycle lands after the old shadow was applied
      if (i_wr) begin
        r_shadow <= i_wr_half;
        r_pend   <= 1'b1;
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_clk_out = r_clk;
  assign o_tick    = r_tick;

endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: load decode plus one div_channel per output.
// All outputs come straight from channel registers.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int CH       = 2,
  parameter int CH_W     = 1,
  parameter int CNT_W    = int'(CNT_W_DEF),
  parameter int DEF_HALF = int'(HALF_150KHZ)
)(
  input logic                 i_clk,
  input logic                 i_reset,
  prog_clock_divider_if.slave bus
);

  logic [CH-1:0] w_wr;
  logic [CH-1:0] w_pend;
  logic [CH-1:0] w_clk;
  logic [CH-1:0] w_tick;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign w_wr[g] = bus.i_load &&
                     (bus.i_load_ch == CH_W'(g));

    div_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_en      (bus.i_en[g]),
      .i_restart (bus.i_restart),
      .i_wr      (w_wr[g]),
      .i_wr_half (bus.i_load_half),
      .o_pend    (w_pend[g]),
      .o_clk_out (w_clk[g]),
      .o_tick    (w_tick[g])
    );
  end

  assign bus.o_pend    = w_pend;
  assign bus.o_clk_out = w_clk;
  assign bus.o_tick    = w_tick;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed scenarios plus random traffic
// checked against a toggle-time model of each channel.
module tb_prog_clock_divider;
  import prog_clock_divider_pkg::*;

  localparam int CH    = 2;
  localparam int CH_W  = 1;
  localparam int CNT_W = 16;
  localparam int DEF   = int'(HALF_150KHZ);

  logic clk;
  logic reset;

  int n_chk;
  int n_fail;

  // Model: absolute edge index of each channel's next toggle
  longint      now;
  longint      m_due  [CH];
  int unsigned m_act  [CH];
  int unsigned m_sh   [CH];
  bit          m_pend [CH];
  bit          m_lvl  [CH];
  bit          m_tick [CH];

  prog_clock_divider_if #(
    .CH(CH), .CH_W(CH_W), .CNT_W(CNT_W)
  ) bus ();

  prog_clock_divider #(
    .CH(CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEF_HALF(DEF)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Half-period = act+1 edges; disabled/restart/reset restart the count
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      m_tick[c] = 1'b0;
      if (reset) begin
        m_act[c]  = DEF;
        m_sh[c]   = DEF;
        m_pend[c] = 1'b0;
        m_lvl[c]  = 1'b0;
        m_due[c]  = now + 1 + DEF;
      end else begin
        if (bus.i_restart) begin
          m_lvl[c] = 1'b0;
          m_due[c] = now + 1 + m_act[c];
        end else if (!bus.i_en[c]) begin
          if (m_pend[c]) begin
            m_act[c]  = m_sh[c];
            m_pend[c] = 1'b0;
          end
          m_lvl[c] = 1'b0;
          m_due[c] = now + 1 + m_act[c];
        end else if (now == m_due[c]) begin
          m_tick[c] = !m_lvl[c];
          m_lvl[c]  = !m_lvl[c];
          if (m_pend[c]) begin
            m_act[c]  = m_sh[c];
            m_pend[c] = 1'b0;
          end
          m_due[c] = now + 1 + m_act[c];
        end
        if (bus.i_load && int'(bus.i_load_ch) == c) begin
          m_sh[c]   = int'(bus.i_load_half);
          m_pend[c] = 1'b1;
        end
      end
    end
    now++;
  endtask

  task automatic step();
    logic [CH-1:0] el, et, ep;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      el[c] = m_lvl[c];
      et[c] = m_tick[c];
      ep[c] = m_pend[c];
    end
    chk("clk_out", 32'(bus.o_clk_out), 32'(el));
    chk("tick", 32'(bus.o_tick), 32'(et));
    chk("pend", 32'(bus.o_pend), 32'(ep));
  endtask

  task automatic load(input int c, input int h);
    bus.i_load      = 1'b1;
    bus.i_load_ch   = CH_W'(c);
    bus.i_load_half = CNT_W'(h);
    step();
    bus.i_load = 1'b0;
  endtask

  // Period between two ticks of channel c, -1 if the budget expires
  task automatic measure(input int c, input int budget,
                         output int per);
    int  t0;
    bit  done;
    t0   = -1;
    per  = -1;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      if (bus.o_tick[c]) begin
        if (t0 < 0) t0 = k;
        else begin
          per  = k - t0;
          done = 1'b1;
        end
      end
    end
  endtask

  // Edges until the first tick on channel c, -1 on timeout
  task automatic first_tick(input int c, input int budget,
                            output int k_out);
    k_out = -1;
    for (int k = 1; k <= budget && k_out < 0; k++) begin
      step();
      if (bus.o_tick[c]) k_out = k;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, s0, f1, s1, p, k;
    n_chk = 0;
    n_fail = 0;
    now = 0;
    reset = 1'b1;
    bus.i_en        = '0;
    bus.i_restart   = 1'b0;
    bus.i_load      = 1'b0;
    bus.i_load_ch   = '0;
    bus.i_load_half = '0;
    for (int c = 0; c < CH; c++) begin
      m_act[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0;
      m_lvl[c] = 0; m_tick[c] = 0; m_due[c] = 0;
    end
    repeat (3) step();
    chk("rst_clk_out", 32'(bus.o_clk_out), 0);
    chk("rst_pend", 32'(bus.o_pend), 0);

    // Default limit, both channels running
    reset = 1'b0;
    bus.i_en = '1;
    f0 = -1; s0 = -1; f1 = -1; s1 = -1;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (bus.o_tick[0]) begin
        if (f0 < 0) f0 = i; else if (s0 < 0) s0 = i;
      end
      if (bus.o_tick[1]) begin
        if (f1 < 0) f1 = i; else if (s1 < 0) s1 = i;
      end
    end
    chk("t1_first0", f0, 333);
    chk("t1_period0", s0 - f0, 666);
    chk("t1_first1", f1, 333);
    chk("t1_period1", s1 - f1, 666);

    // Mid-period load of ch1
    repeat ($urandom_range(50, 250)) step();
    load(1, 4);
    chk("t2_pend", 32'(bus.o_pend[1]), 1);
    repeat (400) step();
    measure(1, 40, p);
    chk("t2_period", p, 10);

    // Load ch0 exactly on its wrap edge
    k = 0;
    while (m_due[0] != now && k < 2000) begin
      step();
      k++;
    end
    chk("t3_found_wrap", 32'(m_due[0] == now), 1);
    load(0, 0);
    chk("t3_pend", 32'(bus.o_pend[0]), 1);
    repeat (340) step();
    measure(0, 10, p);
    chk("t3_period", p, 2);

    // Two loads to ch1 before its wrap
    k = 0;
    while (m_due[1] != now + 4 && k < 50) begin
      step();
      k++;
    end
    bus.i_load      = 1'b1;
    bus.i_load_ch   = CH_W'(1);
    bus.i_load_half = CNT_W'(7);
    step();
    bus.i_load_half = CNT_W'(2);
    step();
    bus.i_load = 1'b0;
    chk("t4_pend", 32'(bus.o_pend[1]), 1);
    repeat (10) step();
    chk("t4_pend_clr", 32'(bus.o_pend[1]), 0);
    measure(1, 30, p);
    chk("t4_period", p, 6);

    // ch0 disabled; a load while idle applies at once
    bus.i_en[0] = 1'b0;
    repeat (5) step();
    chk("t5_low", 32'(bus.o_clk_out[0]), 0);
    load(0, 3);
    step();
    chk("t5_applied", 32'(bus.o_pend[0]), 0);
    repeat (13) step();
    bus.i_en[0] = 1'b1;
    first_tick(0, 50, k);
    chk("t5_first_rise", k, 4);

    // Restart realigns out-of-phase channels
    load(1, 3);
    repeat ($urandom_range(3, 20)) step();
    bus.i_restart = 1'b1;
    step();
    bus.i_restart = 1'b0;
    chk("t6_low", 32'(bus.o_clk_out), 0);
    k = -1;
    for (int i = 1; i <= 50 && k < 0; i++) begin
      step();
      if (bus.o_tick != '0) k = i;
    end
    chk("t6_rise_at", k, 4);
    chk("t6_aligned", 32'(bus.o_tick), 3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0)
        bus.i_en[$urandom_range(0, CH - 1)] ^= 1'b1;
      bus.i_restart = ($urandom_range(0, 199) == 0);
      bus.i_load    = ($urandom_range(0, 15) == 0);
      bus.i_load_ch = CH_W'($urandom_range(0, CH - 1));
      bus.i_load_half = CNT_W'($urandom_range(0, 9));
      step();
    end
    bus.i_load    = 1'b0;
    bus.i_restart = 1'b0;
    bus.i_en      = '1;
    repeat ($urandom_range(5, 30)) step();

    // Asynchronous reset mid-period
    reset = 1'b1;
    #1;
    chk("rst_async_clk", 32'(bus.o_clk_out), 0);
    chk("rst_async_tick", 32'(bus.o_tick), 0);
    chk("rst_async_pend", 32'(bus.o_pend), 0);
    repeat (2) step();
    reset = 1'b0;
    first_tick(1, 400, k);
    chk("t6_def_after_rst", k, 333);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
